program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_3000, is the byte address loaded on reset; only bits [31:2] are used.
REQ-002 Port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port jump_enable, input, 1 bit: when high, load jump_input at the next rising edge.
REQ-005 Port jump_input, input, [31:2] (30 bits): word address of the jump target.
REQ-006 Port pc_value, output, [31:2] (30 bits): current word address of the instruction.
REQ-007 The interface SHALL use one clock, with a synchronous, active-high reset.

Function
REQ-008 pc_value SHALL be driven directly from a 30-bit register, with no combinational path from any input to pc_value.
REQ-009 Update priority at each rising clock edge SHALL be:
- reset=1: load RESET_ADDR[31:2] (30'h0000_0C00 at the default).
- else jump_enable=1: load jump_input.
- else: load pc_value + 1.
REQ-010 Every update SHALL have a latency of one clock: the new value is visible after the edge and stable until the next edge.
REQ-011 The increment SHALL be modulo 2^30: 30'h3FFF_FFFF + 1 = 30'h0000_0000, with no carry out and no error flag.
REQ-012 When reset=1 and jump_enable=1 on the same edge, reset SHALL win and jump_input SHALL be ignored.
REQ-013 jump_input SHALL be ignored whenever jump_enable=0; X or Z on jump_input SHALL NOT propagate into pc_value in that case.
REQ-014 A jump to any 30-bit value SHALL be accepted unmodified, with no alignment or range check.
REQ-015 Back-to-back jumps on consecutive cycles SHALL each take effect on their own edge.
REQ-016 No handshake, stall or enable input SHALL exist; the register advances on every clock edge.

Reset
REQ-017 Reset SHALL be synchronous: asserting reset between edges SHALL NOT change pc_value until the next rising edge.
REQ-018 After any edge sampled with reset=1, pc_value SHALL equal RESET_ADDR[31:2].
REQ-019 pc_value before the first reset edge SHALL be unspecified; the implementation SHALL NOT rely on an initial value.
REQ-020 Reset asserted mid-run SHALL discard the current PC and any pending jump; normal increment SHALL resume on the first edge after reset deasserts.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with clock period 10 ns and checks made 1 ns after each rising edge:
- Initial reset: reset=1 for one edge -> pc_value=30'h0000_0C00.
- Increment: reset=0, jump_enable=0 for two edges -> pc_value=30'h0000_0C01, then 30'h0000_0C02.
- Jump: jump_enable=1, jump_input=30'h1000_F00D -> pc_value=30'h1000_F00D; then jump_enable=0 for one edge -> 30'h1000_F00E.
- Reset priority: reset=1, jump_enable=1, jump_input=30'h1EAD_BEEF -> pc_value=30'h0000_0C00; then release both -> 30'h0000_0C01.
- Wrap: jump to 30'h3FFF_FFFF, then one increment edge -> pc_value=30'h0000_0000.
- Don't-care input: jump_enable=0 with jump_input=X -> pc_value increments normally and never becomes X.
REQ-022 The bench SHALL self-check each scenario against an expected-value model and report pass/fail per edge.

Source files
------------

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// Purpose:
//   30-bit instruction word-address register. On every rising clock edge it
//   does exactly one of three things:
//     - reloads the reset vector,
//     - takes a jump target, or
//     - advances by one word.
//   Reset has the highest priority, then jump, then increment. The increment
//   wraps modulo 2^30. pc_value comes straight from the state register, so
//   there is no combinational path from any input to the output.
//
// Parameters:
//   RESET_ADDR   byte address loaded on reset; only bits [31:2] are used
//
// Ports:
//   clock        single clock; all updates happen on its rising edge
//   reset        synchronous, active-high; reloads RESET_ADDR[31:2]
//   jump_enable  when high, jump_input is loaded at the next edge
//   jump_input   word address of the jump target (ignored unless enabled)
//   pc_value     current instruction word address (registered)
// ---------------------------------------------------------------------------
module program_counter #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_3000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        jump_enable,
   input  logic [31:2] jump_input,
   output logic [31:2] pc_value
);

   // Word-aligned reset vector; the two byte-offset bits are dropped.
   localparam logic [31:2] RESET_WORD = RESET_ADDR[31:2];

   logic [31:2] pc_q;
   logic [31:2] pc_d;

   // Sequential advance. Overflow out of bit 31 is discarded, which gives
   // the required wrap from all-ones back to zero with no carry or flag.
   function automatic logic [31:2] wrap_inc(input logic [31:2] pc);
      return pc + 30'd1;
   endfunction

   // Next-state selection, excluding reset. The jump target is only looked
   // at inside the enabled branch, so an unknown jump_input cannot reach
   // the register while jump_enable is low.
   always_comb begin
      pc_d = wrap_inc(pc_q);
      if (jump_enable) begin
         pc_d = jump_input;
      end
   end

   // State register. Reset is synchronous and overrides any jump that is
   // requested on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q <= RESET_WORD;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_value = pc_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

   localparam logic [29:0] RST_WORD = 30'h0000_0C00;

   logic        clock;
   logic        reset;
   logic        jump_enable;
   logic [29:0] jump_input;
   logic [29:0] pc_value;

   int          vectors;
   int          miscompares;

   // Scoreboard of expected pc_value after each driven edge
   logic [29:0] sb[$];
   // Reference model state, advanced by the bench from the stimulus alone
   logic [29:0] model_pc;

   program_counter #(.RESET_ADDR(32'h0000_3000)) dut (
      .clock       (clock),
      .reset       (reset),
      .jump_enable (jump_enable),
      .jump_input  (jump_input),
      .pc_value    (pc_value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one edge's inputs, record the expected result, and advance to
   // 1 ns after the rising edge where the result is sampled.
   task automatic drive_edge(input logic r, input logic je, input logic [29:0] ji);
      reset       = r;
      jump_enable = je;
      jump_input  = ji;
      if (r)       model_pc = RST_WORD;
      else if (je) model_pc = ji;
      else         model_pc = model_pc + 30'd1;
      sb.push_back(model_pc);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [29:0] exp;
      drive_edge(1'b1, 1'b0, 30'h0);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL reset_init: got %h expected %h", pc_value, exp);
      end
      // A second reset edge must hold the vector
      drive_edge(1'b1, 1'b1, 30'h2345_6789);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL reset_hold: got %h expected %h", pc_value, exp);
      end
   endtask

   task automatic test_increment();
      logic [29:0] exp;
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b0, 1'b0, 30'h0);
         exp = sb.pop_front();
         vectors++;
         if (pc_value !== exp) begin
            miscompares++;
            $display("FAIL increment[%0d]: got %h expected %h", i, pc_value, exp);
         end
      end
   endtask

   task automatic test_jump();
      logic [29:0] exp;
      drive_edge(1'b0, 1'b1, 30'h1000_F00D);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL jump_load: got %h expected %h", pc_value, exp);
      end
      drive_edge(1'b0, 1'b0, 30'h0);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL jump_then_inc: got %h expected %h", pc_value, exp);
      end
   endtask

   task automatic test_reset_priority();
      logic [29:0] exp;
      drive_edge(1'b1, 1'b1, 30'h1EAD_BEEF);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL reset_prio: got %h expected %h", pc_value, exp);
      end
      drive_edge(1'b0, 1'b0, 30'h1EAD_BEEF);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL reset_release: got %h expected %h", pc_value, exp);
      end
   endtask

   task automatic test_wrap();
      logic [29:0] exp;
      drive_edge(1'b0, 1'b1, 30'h3FFF_FFFF);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL wrap_jump: got %h expected %h", pc_value, exp);
      end
      drive_edge(1'b0, 1'b0, 30'h0);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL wrap_inc: got %h expected %h", pc_value, exp);
      end
   endtask

   task automatic test_dont_care();
      logic [29:0] exp;
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b0, 1'b0, 'x);
         exp = sb.pop_front();
         vectors++;
         if (pc_value !== exp) begin
            miscompares++;
            $display("FAIL dont_care[%0d]: got %h expected %h", i, pc_value, exp);
         end
         vectors++;
         if ($isunknown(pc_value)) begin
            miscompares++;
            $display("FAIL dont_care_x[%0d]: got %h expected known value", i, pc_value);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [29:0] targets [4];
      logic [29:0] exp;
      targets = '{30'h0000_0001, 30'h2AAA_AAAA, 30'h1555_5555, 30'h0000_0000};
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b0, 1'b1, targets[i]);
         exp = sb.pop_front();
         vectors++;
         if (pc_value !== exp) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: got %h expected %h", i, pc_value, exp);
         end
      end
   endtask

   // Reset raised between edges must not disturb pc_value until the edge;
   // a jump requested alongside it is dropped.
   task automatic test_sync_reset();
      logic [29:0] exp;
      drive_edge(1'b0, 1'b1, 30'h0ABC_DEF0);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL midrun_jump: got %h expected %h", pc_value, exp);
      end
      #2;
      reset       = 1'b1;
      jump_enable = 1'b1;
      jump_input  = 30'h0123_4567;
      #1;
      vectors++;
      if (pc_value !== model_pc) begin
         miscompares++;
         $display("FAIL sync_reset_between_edges: got %h expected %h", pc_value, model_pc);
      end
      drive_edge(1'b1, 1'b1, 30'h0123_4567);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL midrun_reset: got %h expected %h", pc_value, exp);
      end
      drive_edge(1'b0, 1'b0, 30'h0123_4567);
      exp = sb.pop_front();
      vectors++;
      if (pc_value !== exp) begin
         miscompares++;
         $display("FAIL midrun_resume: got %h expected %h", pc_value, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_pc    = RST_WORD;
      reset       = 1'b1;
      jump_enable = 1'b0;
      jump_input  = 30'h0;
      #2;
      test_reset();
      test_increment();
      test_jump();
      test_reset_priority();
      test_wrap();
      test_dont_care();
      test_back_to_back();
      test_sync_reset();
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
